// File: rtl/uart_recvdata_mess.sv
// UART receiver: 2-flop synchronised rx, mid-bit sampling, 8N1 frames with optional parity.
// Optional parity check is enabled by defining RX_PARITY_EN.
module uart_recvdata_mess #(
    parameter int CLK_DIV    = 434,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
`ifdef RX_PARITY_EN
        PARITY     = 3'd3,
`endif
        STOP       = 3'd4,
        LINE_BREAK = 3'd5
    } state_t;

    localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);

    state_t      state_reg, state_next;
    logic        meta_reg;
    logic        rx_s_reg;
    logic        rx_s_d_reg;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  sh_reg, sh_next;
    logic [7:0]  data_reg, data_next;
    logic        done_reg, done_next;
    logic        ferr_reg, ferr_next;
    logic        busy_reg, busy_next;
    logic        tick;
    logic        parity_bad;

`ifdef RX_PARITY_EN
    logic        parity_bit_reg, parity_bit_next;
    logic        perr_reg, perr_next;

    assign parity_bad = ((^sh_reg) ^ parity_bit_reg) != PARITY_ODD;
    assign parity_err = perr_reg;
`else
    // Parity disabled: both fold to constant 0.
    assign parity_bad = PARITY_ODD & 1'b0;
    assign parity_err = parity_bad;
`endif

    assign tick      = (cnt_reg == 16'd0);
    assign rx_data   = data_reg;
    assign rx_done   = done_reg;
    assign rx_busy   = busy_reg;
    assign frame_err = ferr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg    <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_s_d_reg  <= 1'b1;
            state_reg   <= IDLE;
            cnt_reg     <= 16'd0;
            bit_idx_reg <= 3'd0;
            sh_reg      <= 8'd0;
            data_reg    <= 8'd0;
            done_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef RX_PARITY_EN
            parity_bit_reg <= 1'b0;
            perr_reg       <= 1'b0;
`endif
        end else begin
            meta_reg    <= rx;
            rx_s_reg    <= meta_reg;
            rx_s_d_reg  <= rx_s_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            sh_reg      <= sh_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            ferr_reg    <= ferr_next;
            busy_reg    <= busy_next;
`ifdef RX_PARITY_EN
            parity_bit_reg <= parity_bit_next;
            perr_reg       <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        sh_next      = sh_reg;
        data_next    = data_reg;
        done_next    = 1'b0;
        ferr_next    = 1'b0;
`ifdef RX_PARITY_EN
        parity_bit_next = parity_bit_reg;
        perr_next       = 1'b0;
`endif
        if (state_reg == IDLE) begin
            cnt_next = cnt_reg;
        end else if (tick) begin
            cnt_next = BIT_RELOAD;
        end else begin
            cnt_next = 16'(cnt_reg - 16'd1);
        end

        case (state_reg)
            IDLE: begin
                if (!rx_s_reg && rx_s_d_reg) begin
                    cnt_next   = HALF_RELOAD;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_reg) begin
                        state_next = IDLE;
                    end else begin
                        bit_idx_next = 3'd0;
                        state_next   = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sh_next      = {rx_s_reg, sh_reg[7:1]};
                    bit_idx_next = 3'(bit_idx_reg + 3'd1);
                    if (bit_idx_reg == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    parity_bit_next = rx_s_reg;
                    state_next      = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    // A low stop bit wins over a parity mismatch.
                    if (!rx_s_reg) begin
                        ferr_next  = 1'b1;
                        state_next = LINE_BREAK;
                    end else if (parity_bad) begin
`ifdef RX_PARITY_EN
                        perr_next  = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        data_next  = sh_reg;
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            LINE_BREAK: begin
                if (rx_s_reg) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_recvdata_mess.sv
// Bench for uart_recvdata_mess: directed and random frames scored against a frame-level model.
module tb_uart_recvdata_mess;

    localparam int DIV  = 16;
    localparam bit PODD = 1'b0;
`ifdef RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // Strobe latency in clks, counting the edge that first registers rx=0 as clk 1.
    localparam int LAT = 3 + DIV / 2 + (9 + P) * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    uart_recvdata_mess #(.CLK_DIV(DIV), .PARITY_ODD(PODD)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         kind;   // 0 good byte, 1 framing error, 2 parity error
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         chk_en = 1'b0;
    logic [7:0] model_data = 8'd0;
    int         done_seen = 0;
    int         ferr_seen = 0;
    int         perr_seen = 0;
    int         last_done_cyc = -1;

    // Per-cycle compare of strobes and held byte against the model.
    always @(posedge clk) begin : cmp
        logic [2:0] exp_s;
        ev_t        e;
        cyc = cyc + 1;
        #1;
        if (chk_en) begin
            exp_s = 3'b000;
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                e = evq.pop_front();
                exp_s[e.kind] = 1'b1;
                if (e.kind == 0) model_data = e.data;
            end
            checks++;
            if ({parity_err, frame_err, rx_done} !== exp_s) begin
                failures++;
                $display("FAIL strobes cyc=%0d got perr/ferr/done=%b%b%b want %b", cyc,
                         parity_err, frame_err, rx_done, exp_s);
            end
            checks++;
            if (rx_data !== model_data) begin
                failures++;
                $display("FAIL rx_data cyc=%0d got %h want %h", cyc, rx_data, model_data);
            end
            if (rx_done === 1'b1) begin
                done_seen++;
                last_done_cyc = cyc;
            end
            if (frame_err === 1'b1) ferr_seen++;
            if (parity_err === 1'b1) perr_seen++;
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called just after a negedge; the next posedge registers the start bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int nstop,
                              input bit par_ok, input int hold_low);
        int  ones;
        bit  pbit;
        ev_t e;
        ones = $countones(d);
        pbit = bit'(ones % 2) ^ PODD;
        if (!par_ok) pbit = ~pbit;
        e.cyc  = cyc + LAT;
        e.data = d;
        if (!stop_ok) e.kind = 1;
        else if (P == 1 && ((ones + int'(pbit)) % 2) != int'(PODD)) e.kind = 2;
        else e.kind = 0;
        evq.push_back(e);
        $display("frame data=%h stop_ok=%0d nstop=%0d par_ok=%0d expect_kind=%0d at cyc %0d",
                 d, stop_ok, nstop, par_ok, e.kind, e.cyc);
        rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            idle(DIV);
        end
`ifdef RX_PARITY_EN
        rx = pbit;
        idle(DIV);
`endif
        if (stop_ok) begin
            rx = 1'b1;
            idle(DIV * nstop);
        end else begin
            rx = 1'b0;
            idle(DIV + hold_low);
            rx = 1'b1;
            idle(4);
        end
    endtask

    initial begin
        int t0, d0, f0, p0;
        @(negedge clk);
        chk_en = 1'b1;
        idle(2);
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_busy", int'(rx_busy), 0);
        rst = 1'b0;
        idle(5);

        // 1: single byte, latency pinned by hand
        d0 = done_seen;
        t0 = cyc + 1;
        send_frame(8'hA5, 1'b1, 1, 1'b1, 0);
        check("t1_done_count", done_seen - d0, 1);
        check("t1_latency_cyc", last_done_cyc, t0 + ((P == 1) ? 170 : 154));
        check("t1_rx_data", int'(rx_data), 8'hA5);

        // 2: back-to-back with 2 stop bits
        d0 = done_seen;
        send_frame(8'h00, 1'b1, 2, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 2, 1'b1, 0);
        send_frame(8'h3C, 1'b1, 2, 1'b1, 0);
        check("t2_done_count", done_seen - d0, 3);
        check("t2_rx_data", int'(rx_data), 8'h3C);

        // 3: short glitch
        d0 = done_seen;
        f0 = ferr_seen;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        @(posedge clk);
        #2;
        check("t3_busy_in_start", int'(rx_busy), 1);
        repeat (6) @(posedge clk);
        #2;
        check("t3_busy_cleared", int'(rx_busy), 0);
        @(negedge clk);
        idle(20);
        check("t3_no_strobes", (done_seen - d0) + (ferr_seen - f0), 0);

        // 4: framing error with held-low line, then recovery
        f0 = ferr_seen;
        send_frame(8'h81, 1'b0, 1, 1'b1, 40);
        check("t4_ferr_count", ferr_seen - f0, 1);
        check("t4_rx_data_kept", int'(rx_data), 8'h3C);
        send_frame(8'h5A, 1'b1, 1, 1'b1, 0);
        check("t4_rx_data_next", int'(rx_data), 8'h5A);

        // 5: reset mid-DATA of 8'h77, line abandoned high
        d0 = done_seen;
        rx = 1'b0;
        idle(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = 1'((8'h77 >> i) & 8'h01);
            idle(DIV);
        end
        rx = 1'b1;
        idle(DIV / 2);
        rst = 1'b1;
        evq.delete();
        model_data = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        check("t5_outputs_zero",
              int'({rx_data, rx_done, rx_busy, frame_err, parity_err}), 0);
        idle(20);
        check("t5_no_done", done_seen - d0, 0);
        send_frame(8'h12, 1'b1, 1, 1'b1, 0);
        check("t5_rx_data_next", int'(rx_data), 8'h12);

`ifdef RX_PARITY_EN
        // 6: even parity good and bad
        p0 = perr_seen;
        send_frame(8'h03, 1'b1, 1, 1'b1, 0);
        check("t6_rx_data_good", int'(rx_data), 8'h03);
        send_frame(8'h03, 1'b1, 1, 1'b0, 0);
        check("t6_perr_count", perr_seen - p0, 1);
        check("t6_rx_data_kept", int'(rx_data), 8'h03);
`else
        p0 = perr_seen;
`endif

        // Random frames
        for (int n = 0; n < 40; n++) begin
            logic [7:0] rd;
            bit         sok;
            bit         pok;
            rd  = 8'($urandom_range(0, 255));
            sok = ($urandom_range(0, 9) != 0);
            pok = ($urandom_range(0, 4) != 0);
            send_frame(rd, sok, int'($urandom_range(1, 2)), pok, int'($urandom_range(0, 30)));
            idle(int'($urandom_range(0, 20)));
        end
        if (P == 0) check("no_parity_err", perr_seen - p0, 0);

        idle(LAT + 10);
        check("model_queue_drained", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
